// File: rtl/mux_arb_pkg.sv
// Shared types, sizes and helpers for the round-robin mux arbiter.
//   NREQ        number of requesters sharing the 4:1 mux
//   SEL_W       width of the mux select / requester index
//   state_t     arbiter state (IDLE, BUSY)
//   idx_to_sel  requester index -> {address0, address1}
//   idx_to_onehot requester index -> one-hot grant vector
package mux_arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Select bits are the index itself: address0 is the MSB, address1 the LSB.
    function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] idx);
        return idx;
    endfunction

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first requester at or after 'start'
// (wrapping mod NREQ), optionally ignoring requester 'excl'.
//   req      in   NREQ   request vector
//   start    in   SEL_W  index searched first
//   excl_en  in   1      enable exclusion of 'excl'
//   excl     in   SEL_W  index to exclude (current holder)
//   any      out  1      a winner exists
//   idx      out  SEL_W  winner index (0 when none)
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] start,
    input  logic             excl_en,
    input  logic [SEL_W-1:0] excl,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [NREQ-1:0]  w_req;
    logic [SEL_W-1:0] w_cand;

    // Linear scan from 'start'; index arithmetic wraps naturally in SEL_W bits.
    always_comb begin
        w_req  = excl_en ? (req & ~idx_to_onehot(excl)) : req;
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_cand = start + SEL_W'(i);
            if (!any && w_req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 structural mux between four requesters.
// Grants one source at a time, drives the mux selects to match, and forces
// rotation through a hold timer when the holder keeps the path while others wait.
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   4  request per source
//   grant      out  4  one-hot grant, 0 when idle
//   address0   out  1  mux select MSB
//   address1   out  1  mux select LSB
//   sel_valid  out  1  grant != 0
//   expired    out  1  one-cycle pulse on hold-timer preemption
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            address0,
    output logic            address1,
    output logic            sel_valid,
    output logic            expired
);

    // Saturation point of the hold counter; unused when MAX_HOLD is 0.
    localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    state_t           r_state;
    logic [NREQ-1:0]  r_grant;
    logic             r_addr0;
    logic             r_addr1;
    logic             r_sel_valid;
    logic             r_expired;
    logic [SEL_W-1:0] r_last;
    logic [CNT_W-1:0] r_hold;

    logic             w_busy;
    logic             w_any;
    logic [SEL_W-1:0] w_idx;
    logic             w_holder_drop;
    logic             w_at_limit;
    logic             w_preempt;
    logic             w_take;

    // r_last doubles as the current holder while BUSY.
    assign w_busy = (r_state == BUSY);

    rr_pick u_pick (
        .req     (req),
        .start   (r_last + SEL_W'(1)),
        .excl_en (w_busy),
        .excl    (r_last),
        .any     (w_any),
        .idx     (w_idx)
    );

    // Decision terms for the next edge, in priority order: holder release, then timer.
    always_comb begin
        w_holder_drop = w_busy && !req[r_last];
        w_at_limit    = (MAX_HOLD != 0) && (r_hold == CNT_W'(HOLD_LIM));
        w_preempt     = w_busy && !w_holder_drop && w_at_limit && w_any;
        w_take        = w_any && (!w_busy || w_holder_drop || w_preempt);
    end

    // State, grant/select, hold counter and expired pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_addr0     <= 1'b0;
            r_addr1     <= 1'b0;
            r_sel_valid <= 1'b0;
            r_expired   <= 1'b0;
            r_last      <= SEL_W'(NREQ - 1);
            r_hold      <= '0;
        end else begin
            r_expired <= w_preempt;
            if (w_take) begin
                r_state            <= BUSY;
                r_grant            <= idx_to_onehot(w_idx);
                {r_addr0, r_addr1} <= idx_to_sel(w_idx);
                r_sel_valid        <= 1'b1;
                r_last             <= w_idx;
                r_hold             <= '0;
            end else if (w_holder_drop) begin
                // Selects keep their last value so the mux output stays stable.
                r_state     <= IDLE;
                r_grant     <= '0;
                r_sel_valid <= 1'b0;
            end else if (w_busy && (MAX_HOLD != 0) && !w_at_limit) begin
                r_hold <= r_hold + CNT_W'(1);
            end
        end
    end

    assign grant     = r_grant;
    assign address0  = r_addr0;
    assign address1  = r_addr1;
    assign sel_valid = r_sel_valid;
    assign expired   = r_expired;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic       address0;
    logic       address1;
    logic       sel_valid;
    logic       expired;

    // Behavioural stand-in for the downstream 4:1 mux driven by the selects.
    logic [7:0] din [4];
    logic [7:0] w_mux_out;
    assign w_mux_out = din[{address0, address1}];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] sel;
        logic       sv;
        logic       ex;
    } exp_t;

    exp_t  q  [$];
    string tq [$];

    mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .address0  (address0),
        .address1  (address1),
        .sel_valid (sel_valid),
        .expired   (expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        e = q.pop_front();
        t = tq.pop_front();
        chk({t, "_grant"},   8'(grant),                8'(e.g));
        chk({t, "_sel"},     8'({address0, address1}), 8'(e.sel));
        chk({t, "_valid"},   8'(sel_valid),            8'(e.sv));
        chk({t, "_expired"}, 8'(expired),              8'(e.ex));
        if (e.sv) chk({t, "_mux"}, w_mux_out, din[e.sel]);
    endtask

    // Drive req, record what must appear after the next edge, then compare.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] sel,
                        input logic ex, input string tag);
        exp_t e;
        req = r;
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        e.g   = g;
        e.sel = sel;
        e.sv  = (g != 4'b0000);
        e.ex  = ex;
        q.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"},   8'(grant),                8'h00);
        chk({tag, "_sel"},     8'({address0, address1}), 8'h00);
        chk({tag, "_valid"},   8'(sel_valid),            8'h00);
        chk({tag, "_expired"}, 8'(expired),              8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;

        // 1. Reset with all requests pending, then first grant goes to req0.
        #12;
        chk_reset("t1_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 4'b0001, 2'b00, 1'b0, "t1_first");
        step(4'b0000, 4'b0000, 2'b00, 1'b0, "t1_idle");

        // 2. Single request from IDLE, then drop: selects hold while idle.
        step(4'b0100, 4'b0100, 2'b10, 1'b0, "t2_grant2");
        step(4'b0000, 4'b0000, 2'b10, 1'b0, "t2_hold_sel");

        // Park the pointer on 3 so the rotation below starts at 0.
        step(4'b1000, 4'b1000, 2'b11, 1'b0, "t3_park");
        step(4'b0000, 4'b0000, 2'b11, 1'b0, "t3_park_idle");

        // 3. All request; each holder drops after 2 cycles -> 0,1,2,3,0 with no gaps.
        step(4'b1111, 4'b0001, 2'b00, 1'b0, "t3_g0a");
        step(4'b1111, 4'b0001, 2'b00, 1'b0, "t3_g0b");
        step(4'b1110, 4'b0010, 2'b01, 1'b0, "t3_g1a");
        step(4'b1111, 4'b0010, 2'b01, 1'b0, "t3_g1b");
        step(4'b1101, 4'b0100, 2'b10, 1'b0, "t3_g2a");
        step(4'b1111, 4'b0100, 2'b10, 1'b0, "t3_g2b");
        step(4'b1011, 4'b1000, 2'b11, 1'b0, "t3_g3a");
        step(4'b1111, 4'b1000, 2'b11, 1'b0, "t3_g3b");
        step(4'b0111, 4'b0001, 2'b00, 1'b0, "t3_g0_again");
        step(4'b0000, 4'b0000, 2'b00, 1'b0, "t3_idle");

        // 4. Hold timer: req0 holds 8 cycles, req3 waiting from cycle 2 -> preempt.
        step(4'b0001, 4'b0001, 2'b00, 1'b0, "t4_c1");
        for (int k = 1; k < 8; k++)
            step((k >= 2) ? 4'b1001 : 4'b0001, 4'b0001, 2'b00, 1'b0, $sformatf("t4_c%0d", k + 1));
        step(4'b1001, 4'b1000, 2'b11, 1'b1, "t4_preempt");
        step(4'b1001, 4'b1000, 2'b11, 1'b0, "t4_pulse_end");
        step(4'b0000, 4'b0000, 2'b11, 1'b0, "t4_idle");

        // 5. Lone holder past the limit keeps the grant, no expiry.
        for (int k = 0; k < 20; k++)
            step(4'b0010, 4'b0010, 2'b01, 1'b0, $sformatf("t5_c%0d", k));

        // 6. Asynchronous reset between edges mid-BUSY, then restart from pointer 3.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t6_async");
        req = 4'b1010;
        @(negedge clk);
        chk_reset("t6_held");
        rst_n = 1'b1;
        step(4'b1010, 4'b0010, 2'b01, 1'b0, "t6_first");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
